// File: rtl/fnn_pkg.sv
// Shared types and saturating arithmetic helpers for the fully connected network neurons.
package fnn_pkg;

   typedef enum logic [1:0] {
      ACT_LINEAR = 2'd0,
      ACT_RELU   = 2'd1,
      ACT_HSIG   = 2'd2
   } act_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACCUM = 3'd1,
      BIAS  = 3'd2,
      ACT   = 3'd3,
      DONE  = 3'd4
   } neuron_state_e;

   localparam int unsigned CALC_W = 64;

   // Clamp a sign-extended value into the signed range of a w-bit word (w <= 63).
   function automatic logic signed [CALC_W-1:0] clamp_w(input logic signed [CALC_W-1:0] x,
                                                        input int unsigned w);
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)
         clamp_w = hi;
      else if (x < lo)
         clamp_w = lo;
      else
         clamp_w = x;
   endfunction

   // Addends are w-bit values sign-extended to CALC_W, so the wide sum cannot wrap.
   function automatic logic signed [CALC_W-1:0] sat_add(input logic signed [CALC_W-1:0] a,
                                                        input logic signed [CALC_W-1:0] b,
                                                        input int unsigned w);
      sat_add = clamp_w(a + b, w);
   endfunction

   function automatic logic signed [CALC_W-1:0] sat_narrow(input logic signed [CALC_W-1:0] x,
                                                           input int unsigned w);
      sat_narrow = clamp_w(x, w);
   endfunction

endpackage

// File: rtl/fnn_neuron_mac_act.sv
// Registered activation stage: rescales the accumulator to Q format and applies the activation.
module fnn_act_unit
   import fnn_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned FRAC_W   = 8,
   parameter int unsigned ACT_TYPE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic signed [2*DATA_W-1:0] acc,
   output logic signed [DATA_W-1:0]   result
);

   localparam int unsigned ACC_W = 2 * DATA_W;
   localparam act_e ACT_SEL = act_e'(ACT_TYPE[1:0]);
   localparam logic signed [DATA_W:0] HS_HALF = (DATA_W + 1)'(2 ** (FRAC_W - 1));
   localparam logic signed [DATA_W:0] HS_ONE  = (DATA_W + 1)'(2 ** FRAC_W);

   logic signed [ACC_W-1:0]  shifted;
   logic signed [DATA_W-1:0] x;
   logic signed [DATA_W:0]   hs;
   logic signed [DATA_W-1:0] result_next;

   always_comb begin
      shifted     = acc >>> FRAC_W;
      x           = DATA_W'(sat_narrow(64'(shifted), DATA_W));
      hs          = (DATA_W + 1)'(x >>> 2) + HS_HALF;
      result_next = x;
      case (ACT_SEL)
         ACT_RELU: result_next = x[DATA_W-1] ? '0 : x;
         ACT_HSIG: begin
            if (hs[DATA_W])
               result_next = '0;
            else if (hs > HS_ONE)
               result_next = DATA_W'(HS_ONE);
            else
               result_next = DATA_W'(hs);
         end
         default: result_next = x;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         result <= '0;
      else if (en)
         result <= result_next;
   end

endmodule

// File: rtl/fnn_neuron_mac.sv
// Generic fixed-point neuron: run-time loaded weights/bias, saturating MAC, bias, activation.
module fnn_neuron_mac
   import fnn_pkg::*;
#(
   parameter int unsigned LAYER_ID   = 1,
   parameter int unsigned NEURON_ID  = 0,
   parameter int unsigned NUM_WEIGHT = 30,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FRAC_W     = 8,
   parameter int unsigned ACT_TYPE   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              cfg_layer,
   input  logic [31:0]              cfg_neuron,
   input  logic                     cfg_wvalid,
   input  logic                     cfg_bvalid,
   input  logic [31:0]              cfg_data,
   output logic                     cfg_err,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned ACC_W = 2 * DATA_W;
   localparam int unsigned IDX_W = $clog2(NUM_WEIGHT + 1);
   localparam int unsigned PTR_W = $clog2(NUM_WEIGHT);

   localparam logic [2:0] S_IDLE  = 3'(IDLE);
   localparam logic [2:0] S_ACCUM = 3'(ACCUM);
   localparam logic [2:0] S_BIAS  = 3'(BIAS);
   localparam logic [2:0] S_ACT   = 3'(ACT);
   localparam logic [2:0] S_DONE  = 3'(DONE);

   logic [2:0]               state, state_next;
   logic [IDX_W-1:0]         idx, idx_next;
   logic [PTR_W-1:0]         wptr, wptr_next;
   logic signed [ACC_W-1:0]  acc, acc_next;
   logic signed [ACC_W-1:0]  prod, prod_next;
   logic                     prod_valid, prod_valid_next;
   logic signed [DATA_W-1:0] bias, bias_next;
   logic                     in_ready_next;
   logic                     out_valid_next;
   logic                     cfg_err_next;
   logic                     w_we;
   logic                     act_en;
   logic                     cfg_match;
   logic                     accept;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [DATA_W-1:0] w_mem [NUM_WEIGHT];
   logic                     unused_cfg;

   assign unused_cfg = ^cfg_data[31:DATA_W];

   always_comb begin
      state_next      = state;
      idx_next        = idx;
      wptr_next       = wptr;
      acc_next        = acc;
      prod_next       = prod;
      prod_valid_next = 1'b0;
      bias_next       = bias;
      out_valid_next  = out_valid;
      w_we            = 1'b0;
      act_en          = 1'b0;
      cfg_match       = (cfg_layer == 32'(LAYER_ID)) && (cfg_neuron == 32'(NEURON_ID));
      cfg_err_next    = cfg_match && (cfg_wvalid || cfg_bvalid) && (state != S_IDLE);
      accept          = in_valid && in_ready;
      bias_ext        = ACC_W'(bias) <<< FRAC_W;

      // Two-stage MAC: multiply on accept, accumulate one edge later.
      if (accept) begin
         prod_next       = ACC_W'(in_data) * ACC_W'(w_mem[idx[PTR_W-1:0]]);
         prod_valid_next = 1'b1;
         idx_next        = idx + IDX_W'(1);
      end
      if (prod_valid)
         acc_next = ACC_W'(sat_add(64'(acc), 64'(prod), ACC_W));

      case (state)
         S_IDLE: begin
            if (cfg_match && cfg_wvalid) begin
               w_we      = 1'b1;
               wptr_next = (wptr == PTR_W'(NUM_WEIGHT - 1)) ? '0 : wptr + PTR_W'(1);
            end
            if (cfg_match && cfg_bvalid)
               bias_next = cfg_data[DATA_W-1:0];
            if (accept)
               state_next = S_ACCUM;
         end
         S_ACCUM: begin
            if ((idx == IDX_W'(NUM_WEIGHT)) && !prod_valid)
               state_next = S_BIAS;
         end
         S_BIAS: begin
            acc_next   = ACC_W'(sat_add(64'(acc), 64'(bias_ext), ACC_W));
            state_next = S_ACT;
         end
         S_ACT: begin
            act_en         = 1'b1;
            out_valid_next = 1'b1;
            state_next     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               idx_next       = '0;
               acc_next       = '0;
               state_next     = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      in_ready_next = ((state_next == S_IDLE) || (state_next == S_ACCUM)) &&
                      (idx_next < IDX_W'(NUM_WEIGHT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         wptr       <= '0;
         acc        <= '0;
         prod       <= '0;
         prod_valid <= 1'b0;
         bias       <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         wptr       <= wptr_next;
         acc        <= acc_next;
         prod       <= prod_next;
         prod_valid <= prod_valid_next;
         bias       <= bias_next;
         in_ready   <= in_ready_next;
         out_valid  <= out_valid_next;
         cfg_err    <= cfg_err_next;
      end
   end

   // Weight storage keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (w_we)
         w_mem[wptr] <= cfg_data[DATA_W-1:0];
   end

   fnn_act_unit #(
      .DATA_W   (DATA_W),
      .FRAC_W   (FRAC_W),
      .ACT_TYPE (ACT_TYPE)
   ) u_act (
      .clk    (clk),
      .rst    (rst),
      .en     (act_en),
      .acc    (acc),
      .result (out_data)
   );

endmodule

// File: tb/tb_fnn_neuron_mac.sv
// Scoreboard bench: three neurons (linear, ReLU, hard sigmoid) share one config bus and input stream.
module tb_fnn_neuron_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cfg_layer, cfg_neuron, cfg_data;
   logic        cfg_wvalid, cfg_bvalid;
   logic [15:0] in_data;
   logic        in_valid, out_ready;
   logic        err_lin, err_relu, err_hsig;
   logic        rdy_lin, rdy_relu, rdy_hsig;
   logic [15:0] out_lin, out_relu, out_hsig;
   logic        ov_lin, ov_relu, ov_hsig;

   int checks = 0;
   int errors = 0;
   logic [15:0] q_lin[$];
   logic [15:0] q_relu[$];
   logic [15:0] q_hsig[$];

   always #5 clk = ~clk;

   fnn_neuron_mac #(.LAYER_ID(1), .NEURON_ID(0), .NUM_WEIGHT(4), .DATA_W(16), .FRAC_W(8), .ACT_TYPE(0)) u_lin (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_wvalid(cfg_wvalid),
      .cfg_bvalid(cfg_bvalid), .cfg_data(cfg_data), .cfg_err(err_lin), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy_lin), .out_data(out_lin), .out_valid(ov_lin), .out_ready(out_ready));

   fnn_neuron_mac #(.LAYER_ID(1), .NEURON_ID(0), .NUM_WEIGHT(4), .DATA_W(16), .FRAC_W(8), .ACT_TYPE(1)) u_relu (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_wvalid(cfg_wvalid),
      .cfg_bvalid(cfg_bvalid), .cfg_data(cfg_data), .cfg_err(err_relu), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy_relu), .out_data(out_relu), .out_valid(ov_relu), .out_ready(out_ready));

   fnn_neuron_mac #(.LAYER_ID(1), .NEURON_ID(0), .NUM_WEIGHT(4), .DATA_W(16), .FRAC_W(8), .ACT_TYPE(2)) u_hsig (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_wvalid(cfg_wvalid),
      .cfg_bvalid(cfg_bvalid), .cfg_data(cfg_data), .cfg_err(err_hsig), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy_hsig), .out_data(out_hsig), .out_valid(ov_hsig), .out_ready(out_ready));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [15:0] lin, input logic [15:0] relu, input logic [15:0] hsig);
      q_lin.push_back(lin);
      q_relu.push_back(relu);
      q_hsig.push_back(hsig);
   endtask

   task automatic cfg_write(input logic [31:0] layer, input logic [31:0] neuron,
                            input logic wv, input logic bv, input logic [31:0] data);
      @(negedge clk);
      cfg_layer  = layer;
      cfg_neuron = neuron;
      cfg_wvalid = wv;
      cfg_bvalid = bv;
      cfg_data   = data;
      @(negedge clk);
      cfg_wvalid = 1'b0;
      cfg_bvalid = 1'b0;
   endtask

   task automatic load(input logic [15:0] w, input logic [15:0] b);
      for (int i = 0; i < 4; i++)
         cfg_write(32'd1, 32'd0, 1'b1, 1'b0, {16'h0000, w});
      cfg_write(32'd1, 32'd0, 1'b0, 1'b1, {16'h0000, b});
   endtask

   // One sample; returns just after the accepting edge.
   task automatic send(input logic [15:0] d);
      int n;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!(rdy_lin && rdy_relu && rdy_hsig) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout in_ready stayed %b%b%b required 111", rdy_lin, rdy_relu, rdy_hsig);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [15:0] d, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         if (gaps)
            repeat ($urandom_range(0, 3)) @(negedge clk);
         send(d);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_lin.size() + q_relu.size() + q_hsig.size()) != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending %0d required 0", q_relu.size());
      end
      @(negedge clk);
   endtask

   // Monitor: pop and compare whenever a result is handed over.
   always @(negedge clk) begin
      if (ov_lin && out_ready) begin
         if (q_lin.size() == 0) begin
            checks++; errors++;
            $display("FAIL lin_unexpected out %h required none", out_lin);
         end else
            check("lin_out", 32'(out_lin), 32'(q_lin.pop_front()));
      end
      if (ov_relu && out_ready) begin
         if (q_relu.size() == 0) begin
            checks++; errors++;
            $display("FAIL relu_unexpected out %h required none", out_relu);
         end else
            check("relu_out", 32'(out_relu), 32'(q_relu.pop_front()));
      end
      if (ov_hsig && out_ready) begin
         if (q_hsig.size() == 0) begin
            checks++; errors++;
            $display("FAIL hsig_unexpected out %h required none", out_hsig);
         end else
            check("hsig_out", 32'(out_hsig), 32'(q_hsig.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int k;
      rst = 1'b1;
      cfg_layer = '0; cfg_neuron = '0; cfg_data = '0;
      cfg_wvalid = 1'b0; cfg_bvalid = 1'b0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'({ov_lin, ov_relu, ov_hsig}), 32'(3'b000));
      check("rst_out_data", 32'(out_lin | out_relu | out_hsig), 32'h0);
      check("rst_cfg_err", 32'({err_lin, err_relu, err_hsig}), 32'(3'b000));
      check("rst_in_ready", 32'({rdy_lin, rdy_relu, rdy_hsig}), 32'(3'b111));

      // 1.0 * 1.0 * 4 + 0.5 bias, with latency measurement
      load(16'h0100, 16'h0080);
      push_exp(16'h0480, 16'h0480, 16'h0100);
      send_vec(16'h0100, 1'b0);
      k = 0;
      @(negedge clk);
      while (!ov_relu && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("latency", 32'(k), 32'd4);
      drain();

      // negative inputs, zero bias
      cfg_write(32'd1, 32'd0, 1'b0, 1'b1, 32'h0);
      push_exp(16'hFC00, 16'h0000, 16'h0000);
      send_vec(16'hFF00, 1'b0);
      drain();

      // positive and negative accumulator saturation
      load(16'h7FFF, 16'h0000);
      push_exp(16'h7FFF, 16'h7FFF, 16'h0100);
      send_vec(16'h7FFF, 1'b0);
      push_exp(16'h8000, 16'h0000, 16'h0000);
      send_vec(16'h8000, 1'b0);
      drain();

      // back-pressure: hold out_ready low, then release into the next vector
      load(16'h0100, 16'h0080);
      @(posedge clk);
      #1 out_ready = 1'b0;
      push_exp(16'h0480, 16'h0480, 16'h0100);
      send_vec(16'h0100, 1'b0);
      k = 0;
      while (!ov_relu && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (10) begin
         @(negedge clk);
         check("hold_relu", 32'({ov_relu, rdy_relu, out_relu}), 32'({1'b1, 1'b0, 16'h0480}));
         check("hold_lin_hsig", 32'({out_lin, out_hsig}), 32'({16'h0480, 16'h0100}));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_exp(16'hFC80, 16'h0000, 16'h0000);
      in_data  = 16'hFF00;
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_restart", 32'({ov_relu, rdy_relu}), 32'({1'b0, 1'b1}));
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 3; i++)
         send(16'hFF00);
      drain();

      // rejected write during accumulation, ignored foreign writes
      push_exp(16'h0480, 16'h0480, 16'h0100);
      send(16'h0100);
      send(16'h0100);
      cfg_write(32'd1, 32'd0, 1'b1, 1'b0, 32'h0000_0200);
      check("cfg_err_pulse", 32'({err_lin, err_relu, err_hsig}), 32'(3'b111));
      @(negedge clk);
      check("cfg_err_clear", 32'({err_lin, err_relu, err_hsig}), 32'(3'b000));
      send(16'h0100);
      send(16'h0100);
      drain();
      cfg_write(32'd1, 32'd5, 1'b1, 1'b0, 32'h0000_0300);
      check("foreign_neuron_err", 32'({err_lin, err_relu, err_hsig}), 32'(3'b000));
      cfg_write(32'd2, 32'd0, 1'b0, 1'b1, 32'h0000_7F00);
      check("foreign_layer_err", 32'({err_lin, err_relu, err_hsig}), 32'(3'b000));
      push_exp(16'h0480, 16'h0480, 16'h0100);
      send_vec(16'h0100, 1'b0);
      drain();

      // reset mid-vector (bias clears, weights survive), then gapped input
      push_exp(16'h0400, 16'h0400, 16'h0100);
      send(16'hFF00);
      send(16'hFF00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_vec(16'h0100, 1'b1);
      drain();
      cfg_write(32'd1, 32'd0, 1'b0, 1'b1, 32'h0000_0080);
      push_exp(16'h0480, 16'h0480, 16'h0100);
      send_vec(16'h0100, 1'b1);
      drain();

      repeat (10) @(negedge clk);
      check("leftover_lin", 32'(q_lin.size()), 32'd0);
      check("leftover_relu", 32'(q_relu.size()), 32'd0);
      check("leftover_hsig", 32'(q_hsig.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fnn_neuron_mac.md
Name: fnn_neuron_mac

Overview:
Parametrised fixed-point neuron for the fully connected network accelerator. It replaces the per-neuron hard-coded blocks with one generic module. Weights and bias are loaded at run time over the shared config bus, matched on layer and neuron number. The block runs a saturating multiply-accumulate over NUM_WEIGHT streamed inputs using a valid/ready handshake, adds the bias, applies a selectable activation and holds the result until the consumer takes it.

Parameters:
LAYER_ID, 1, layer number this neuron answers to on the config bus
NEURON_ID, 0, neuron number this neuron answers to on the config bus
NUM_WEIGHT, 30, inputs per vector (>=2)
DATA_W, 16, signed width of input, weight, bias and output
FRAC_W, 8, fractional bits of input, weight, bias and output (Q format)
ACT_TYPE, 1, activation: 0 = linear, 1 = ReLU, 2 = hard sigmoid

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_layer  in  32  layer select for config writes
cfg_neuron  in  32  neuron select for config writes
cfg_wvalid  in  1  weight write strobe
cfg_bvalid  in  1  bias write strobe
cfg_data  in  32  config data; low DATA_W bits used
cfg_err  out  1  one-cycle pulse: matched config write rejected (busy)
in_data  in  DATA_W  input sample
in_valid  in  1  input valid
in_ready  out  1  neuron accepts input
out_data  out  DATA_W  activated result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset: state IDLE; weight write pointer 0; input index 0; accumulator 0; bias register 0; out_valid 0; out_data 0; cfg_err 0. Weight array contents are not reset.
- A config write matches when cfg_layer==LAYER_ID and cfg_neuron==NEURON_ID.
- Matched cfg_wvalid in IDLE: w[wptr] <= cfg_data[DATA_W-1:0]. wptr increments and wraps from NUM_WEIGHT-1 to 0.
- Matched cfg_bvalid in IDLE: bias <= cfg_data[DATA_W-1:0].
- cfg_wvalid and cfg_bvalid in the same cycle: both writes are performed.
- Matched write outside IDLE: ignored; cfg_err pulses high for 1 cycle. Unmatched writes are ignored silently.
- in_ready = (state==IDLE or ACCUM) and idx<NUM_WEIGHT. An accept is in_valid & in_ready.
- States:
  - IDLE: the first accept goes to ACCUM.
  - ACCUM: stays until the product of the last sample has been accumulated, then goes to BIAS.
  - BIAS: one cycle, goes to ACT.
  - ACT: one cycle, goes to DONE.
  - DONE: out_valid=1 and out_data held. On out_ready, goes to IDLE and clears idx and acc.
- Pipeline: an accept on edge e0 registers prod <= in_data * w[idx] (signed, 2*DATA_W) on e0 and increments idx. On e1, acc <= sat(acc + prod).
- Input gaps (in_valid low) stall accumulation without error.
- Bias step: acc <= sat(acc + (sign-extended bias <<< FRAC_W)).
- Activation: x = sat_DATA_W(acc >>> FRAC_W), arithmetic shift.
  - Linear: x.
  - ReLU: 0 if x<0, else x.
  - Hard sigmoid: clamp((x>>>2) + 2^(FRAC_W-1), 0, 2^FRAC_W).
- Latency: the last accept on edge 0 gives out_valid high after edge 4. With in_valid held high, throughput is one vector per NUM_WEIGHT+5 cycles when out_ready is high.
- Saturation: if both addends are non-negative and the sum is negative, the result is the max positive value. If both are negative and the sum is non-negative, the result is the min negative value. The DATA_W narrowing clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- out_valid drops the cycle after the out_ready handshake; out_data keeps its last value.
- rst asserted mid-vector aborts the vector and loses the partial sum; no output is produced.

Decomposition:
- Package fnn_pkg:
  - act_e enum (ACT_LINEAR, ACT_RELU, ACT_HSIG)
  - neuron_state_e enum (IDLE, ACCUM, BIAS, ACT, DONE)
  - functions sat_add(a, b) and sat_narrow(x)
- Sub-module fnn_act_unit: registered activation stage, parameters DATA_W, FRAC_W, ACT_TYPE.

Test Plan:
All scenarios use DATA_W=16, FRAC_W=8, NUM_WEIGHT=4.
1. Load weights 4x0x0100 and bias 0x0080; stream 4x0x0100 with ACT=ReLU -> out_data=0x0480 exactly 4 cycles after the last accept. With ACT=hard sigmoid, same stream -> 0x0100.
2. Inputs 4x0xFF00 (-1.0), weights 1.0, bias 0. ReLU -> 0x0000. Linear -> 0xFC00.
3. Inputs and weights 4x0x7FFF -> accumulator saturates at 0x7FFFFFFF -> out_data=0x7FFF. Negative mirror (inputs 0x8000, weights 0x7FFF) -> 0x8000.
4. Hold out_ready low for 10 cycles -> out_valid and out_data stable, in_ready=0. Release -> next vector is accepted one cycle later.
5. Matched cfg_wvalid during ACCUM -> cfg_err pulses once and weights are unchanged (the repeated vector gives an identical result). A write with a mismatched neuron number -> no effect and no cfg_err.
6. rst after 2 accepts, then a full vector -> only one out_valid, carrying the correct result of the new vector. Random in_valid gaps -> same result as back-to-back input.
